// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller for a 32-bit SRAM pair (two 64Kx16 chips).
// Arbitrates the debug port (priority) against the core load/store port.
// Builds store byte lanes and aligns/extends load data. Sequences SRAM
// setup/strobe/hold timing.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   core_*              - core load/store request/ack interface
//   dbg_*               - debug word access request/ack interface
//   busy                - controller is not idle
//   sram_addr/ce_n/oe_n/we_n/be_n - SRAM address and strobes (active low)
//   sram_dq_o/dq_oe/dq_i - split data bus toward the top-level tristate
module dmem_ctrl #(
  parameter int unsigned RD_WAIT  = 1,
  parameter int unsigned WR_PULSE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [1:0]  core_size,
  input  logic        core_uns,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic        core_ack,
  output logic        core_err,
  output logic [31:0] core_rdata,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ack,
  output logic [31:0] dbg_rdata,
  output logic        busy,
  output logic [15:0] sram_addr,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic [3:0]  sram_be_n,
  output logic [31:0] sram_dq_o,
  output logic        sram_dq_oe,
  input  logic [31:0] sram_dq_i
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               own_dbg_q, own_dbg_d;
  logic [1:0]         size_q, size_d;
  logic               uns_q, uns_d;
  logic [1:0]         off_q, off_d;

  logic               core_ack_d, core_err_d, dbg_ack_d, busy_d;
  logic [31:0]        core_rdata_d, dbg_rdata_d;
  logic [15:0]        sram_addr_d;
  logic               sram_ce_n_d, sram_oe_n_d, sram_we_n_d, sram_dq_oe_d;
  logic [3:0]         sram_be_n_d;
  logic [31:0]        sram_dq_o_d;

  // Selected request fields (debug wins); debug is always an aligned word.
  logic               sel_we;
  logic [1:0]         sel_size;
  logic               sel_uns;
  logic [1:0]         sel_off;
  logic [15:0]        sel_waddr;
  logic [31:0]        sel_wdata;
  logic               sel_bad;
  logic [3:0]         lane_be_n;
  logic [31:0]        lane_dq;
  logic [31:0]        rd_shift;
  logic [31:0]        rd_load;

  // Address bits outside the 256 KiB window, and debug byte offset, are don't-care.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{core_addr[31:18], dbg_addr[31:18], dbg_addr[1:0]};

  // Request selection and core alignment check
  always_comb begin
    sel_we    = dbg_req ? dbg_we : core_we;
    sel_size  = dbg_req ? 2'b10 : core_size;
    sel_uns   = dbg_req ? 1'b0 : core_uns;
    sel_off   = dbg_req ? 2'b00 : core_addr[1:0];
    sel_waddr = dbg_req ? dbg_addr[17:2] : core_addr[17:2];
    sel_wdata = dbg_req ? dbg_wdata : core_wdata;
    sel_bad   = 1'b0;
    if (!dbg_req) begin
      unique case (core_size)
        2'b00:   sel_bad = 1'b0;
        2'b01:   sel_bad = core_addr[0];
        2'b10:   sel_bad = (core_addr[1:0] != 2'b00);
        default: sel_bad = 1'b1;
      endcase
    end
  end

  // Store lane replication and byte enables
  always_comb begin
    lane_be_n = 4'b0000;
    lane_dq   = sel_wdata;
    unique case (sel_size)
      2'b00: begin
        lane_be_n = ~(4'b0001 << sel_off);
        lane_dq   = {4{sel_wdata[7:0]}};
      end
      2'b01: begin
        lane_be_n = sel_off[1] ? 4'b0011 : 4'b1100;
        lane_dq   = {2{sel_wdata[15:0]}};
      end
      default: begin
        lane_be_n = 4'b0000;
        lane_dq   = sel_wdata;
      end
    endcase
  end

  // Load alignment and extension from the raw bus word
  always_comb begin
    rd_shift = sram_dq_i >> {off_q, 3'b000};
    unique case (size_q)
      2'b00:   rd_load = {{24{~uns_q & rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   rd_load = {{16{~uns_q & rd_shift[15]}}, rd_shift[15:0]};
      default: rd_load = rd_shift;
    endcase
  end

  // Next-state and next-output logic; SRAM controls default to idle
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    own_dbg_d    = own_dbg_q;
    size_d       = size_q;
    uns_d        = uns_q;
    off_d        = off_q;
    core_ack_d   = 1'b0;
    core_err_d   = 1'b0;
    dbg_ack_d    = 1'b0;
    core_rdata_d = core_rdata;
    dbg_rdata_d  = dbg_rdata;
    sram_addr_d  = sram_addr;
    sram_ce_n_d  = 1'b1;
    sram_oe_n_d  = 1'b1;
    sram_we_n_d  = 1'b1;
    sram_be_n_d  = 4'hF;
    sram_dq_o_d  = sram_dq_o;
    sram_dq_oe_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (dbg_req || core_req) begin
          own_dbg_d = dbg_req;
          size_d    = sel_size;
          uns_d     = sel_uns;
          off_d     = sel_off;
          if (sel_bad) begin
            // Rejected core access: ack with error, no SRAM cycle
            state_d      = S_DONE;
            core_ack_d   = 1'b1;
            core_err_d   = 1'b1;
            core_rdata_d = '0;
          end else if (!sel_we) begin
            state_d     = S_READ;
            cnt_d       = '0;
            sram_addr_d = sel_waddr;
            sram_ce_n_d = 1'b0;
            sram_oe_n_d = 1'b0;
            sram_be_n_d = 4'b0000;
          end else begin
            state_d      = S_SETUP;
            sram_addr_d  = sel_waddr;
            sram_ce_n_d  = 1'b0;
            sram_be_n_d  = lane_be_n;
            sram_dq_o_d  = lane_dq;
            sram_dq_oe_d = 1'b1;
          end
        end
      end

      S_READ: begin
        if (cnt_q == CNT_W'(RD_WAIT)) begin
          // Last read cycle: capture and release the bus
          state_d = S_DONE;
          if (own_dbg_q) begin
            dbg_ack_d   = 1'b1;
            dbg_rdata_d = sram_dq_i;
          end else begin
            core_ack_d   = 1'b1;
            core_rdata_d = rd_load;
          end
        end else begin
          cnt_d       = cnt_q + CNT_W'(1);
          sram_ce_n_d = 1'b0;
          sram_oe_n_d = 1'b0;
          sram_be_n_d = 4'b0000;
        end
      end

      S_SETUP: begin
        state_d      = S_STROBE;
        cnt_d        = '0;
        sram_ce_n_d  = 1'b0;
        sram_we_n_d  = 1'b0;
        sram_be_n_d  = sram_be_n;
        sram_dq_oe_d = 1'b1;
      end

      S_STROBE: begin
        sram_ce_n_d  = 1'b0;
        sram_be_n_d  = sram_be_n;
        sram_dq_oe_d = 1'b1;
        if (cnt_q == CNT_W'(WR_PULSE - 1)) begin
          state_d     = S_HOLD;
          sram_we_n_d = 1'b1;
        end else begin
          cnt_d       = cnt_q + CNT_W'(1);
          sram_we_n_d = 1'b0;
        end
      end

      S_HOLD: begin
        state_d = S_DONE;
        if (own_dbg_q) begin
          dbg_ack_d = 1'b1;
        end else begin
          core_ack_d = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      own_dbg_q  <= 1'b0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      off_q      <= 2'b00;
      core_ack   <= 1'b0;
      core_err   <= 1'b0;
      dbg_ack    <= 1'b0;
      busy       <= 1'b0;
      core_rdata <= '0;
      dbg_rdata  <= '0;
      sram_addr  <= '0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_be_n  <= 4'hF;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      own_dbg_q  <= own_dbg_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      off_q      <= off_d;
      core_ack   <= core_ack_d;
      core_err   <= core_err_d;
      dbg_ack    <= dbg_ack_d;
      busy       <= busy_d;
      core_rdata <= core_rdata_d;
      dbg_rdata  <= dbg_rdata_d;
      sram_addr  <= sram_addr_d;
      sram_ce_n  <= sram_ce_n_d;
      sram_oe_n  <= sram_oe_n_d;
      sram_we_n  <= sram_we_n_d;
      sram_be_n  <= sram_be_n_d;
      sram_dq_o  <= sram_dq_o_d;
      sram_dq_oe <= sram_dq_oe_d;
    end
  end

endmodule
